// File: rtl/demux_deserializer.sv
// Serial-to-parallel lane demultiplexer: steers each accepted bit to the lane
// named by an internal counter and hands the rebuilt word over valid/ready.
module demux_deserializer #(
  parameter int unsigned LANES = 16,
  parameter int unsigned SELW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             frame_start,
  output logic [SELW-1:0]  lane_idx,
  output logic [LANES-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err
);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  localparam logic [SELW-1:0] LAST_IDX = SELW'(LANES - 1);

  state_t           state, state_nxt;
  logic [SELW-1:0]  idx, idx_nxt;
  logic [LANES-1:0] shadow, shadow_nxt;
  logic [LANES-1:0] word_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic             at_last;
  logic             accept;

  assign at_last  = (idx == LAST_IDX);
  assign lane_idx = idx;

  // State register, including the datapath registers it governs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      shadow    <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      shadow    <= shadow_nxt;
      out_word  <= word_nxt;
      out_valid <= valid_nxt;
      frame_err <= err_nxt;
    end
  end

  // Next-state logic: frame_start always restarts a word, a completing bit
  // returns to IDLE, any other accepted bit leaves the word partially filled.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (frame_start) begin
        state_nxt = FILL;
      end else if (at_last) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = FILL;
      end
    end
  end

  // Output and datapath logic.
  always_comb begin
    in_ready   = !(at_last && out_valid && !out_ready);
    accept     = in_valid && in_ready;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    word_nxt   = out_word;
    valid_nxt  = out_valid;
    err_nxt    = 1'b0;

    if (out_valid && out_ready) begin
      valid_nxt = 1'b0;
    end

    if (accept) begin
      if (frame_start) begin
        shadow_nxt    = '0;
        shadow_nxt[0] = in_bit;
        idx_nxt       = SELW'(1);
        err_nxt       = (state == FILL);
      end else if (at_last) begin
        // A completing bit may coincide with the consume; the new word wins.
        word_nxt            = shadow;
        word_nxt[LANES-1]   = in_bit;
        valid_nxt           = 1'b1;
        idx_nxt             = '0;
        shadow_nxt          = '0;
      end else begin
        shadow_nxt[idx] = in_bit;
        idx_nxt         = idx + SELW'(1);
      end
    end
  end

endmodule
